// File: rtl/lc3b_pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage LC-3b pipeline: latch enables, bubbles,
// fetch/data-access tracking (including two-access LDI/STI) and a saturating stall counter.
module lc3b_pipeline_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   imem_resp,
    input  logic                   dmem_resp,
    input  logic                   mem_access,
    input  logic                   mem_indirect,
    input  logic                   load_use,
    input  logic                   branch_taken,
    output logic                   imem_read,
    output logic                   dmem_req,
    output logic                   dmem_phase,
    output logic                   load_pc,
    output logic                   load_ifid,
    output logic                   load_idex,
    output logic                   load_exmem,
    output logic                   load_memwb,
    output logic                   bubble_ifid,
    output logic                   bubble_idex,
    output logic                   bubble_exmem,
    output logic                   pc_sel_branch,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_ACC1 = 2'd1,
        M_ACC2 = 2'd2
    } mstate_t;

    mstate_t                mstate_q, mstate_d;
    logic                   fetched_q, fetched_d;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

    logic mem_complete_s;
    logic mem_ok_s;
    logic fetch_ok_s;
    logic load_pc_s, load_ifid_s, load_idex_s, load_exmem_s, load_memwb_s;
    logic bubble_ifid_s, bubble_idex_s, bubble_exmem_s, pc_sel_branch_s;

    // State register: fetch flag, MEM FSM and stall counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mstate_q      <= M_IDLE;
            fetched_q     <= 1'b0;
            stall_count_q <= '0;
        end else begin
            mstate_q      <= mstate_d;
            fetched_q     <= fetched_d;
            stall_count_q <= stall_count_d;
        end
    end

    // MEM FSM next state and same-cycle completion pulse
    always_comb begin
        mstate_d       = mstate_q;
        mem_complete_s = 1'b0;
        case (mstate_q)
            M_IDLE: begin
                if (mem_access) begin
                    mstate_d = M_ACC1;
                end else begin
                    mstate_d = M_IDLE;
                end
            end
            M_ACC1: begin
                if (dmem_resp && mem_indirect) begin
                    mstate_d = M_ACC2;
                end else if (dmem_resp) begin
                    mstate_d       = M_IDLE;
                    mem_complete_s = 1'b1;
                end else begin
                    mstate_d = M_ACC1;
                end
            end
            M_ACC2: begin
                if (dmem_resp) begin
                    mstate_d       = M_IDLE;
                    mem_complete_s = 1'b1;
                end else begin
                    mstate_d = M_ACC2;
                end
            end
            default: begin
                mstate_d = M_IDLE;
            end
        endcase
    end

    // Stage enables in priority order: branch flush, load-use bubble, advance, stall
    always_comb begin
        mem_ok_s        = !mem_access || mem_complete_s;
        fetch_ok_s      = imem_resp || fetched_q;
        load_pc_s       = 1'b0;
        load_ifid_s     = 1'b0;
        load_idex_s     = 1'b0;
        load_exmem_s    = 1'b0;
        load_memwb_s    = 1'b0;
        bubble_ifid_s   = 1'b0;
        bubble_idex_s   = 1'b0;
        bubble_exmem_s  = 1'b0;
        pc_sel_branch_s = 1'b0;
        if (branch_taken && mem_ok_s) begin
            load_pc_s       = 1'b1;
            load_ifid_s     = 1'b1;
            load_idex_s     = 1'b1;
            load_exmem_s    = 1'b1;
            load_memwb_s    = 1'b1;
            bubble_ifid_s   = 1'b1;
            bubble_idex_s   = 1'b1;
            bubble_exmem_s  = 1'b1;
            pc_sel_branch_s = 1'b1;
        end else if (load_use && mem_ok_s) begin
            load_idex_s   = 1'b1;
            bubble_idex_s = 1'b1;
            load_exmem_s  = 1'b1;
            load_memwb_s  = 1'b1;
        end else if (fetch_ok_s && mem_ok_s) begin
            load_pc_s    = 1'b1;
            load_ifid_s  = 1'b1;
            load_idex_s  = 1'b1;
            load_exmem_s = 1'b1;
            load_memwb_s = 1'b1;
        end else begin
            load_pc_s = 1'b0;
        end
    end

    // Fetch hold flag and saturating stall counter
    always_comb begin
        fetched_d     = fetched_q;
        stall_count_d = stall_count_q;
        if (load_ifid_s) begin
            fetched_d = 1'b0;
        end else if (imem_resp) begin
            fetched_d = 1'b1;
        end else begin
            fetched_d = fetched_q;
        end
        if (!load_pc_s && (stall_count_q != {STALL_CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // Output drive; everything is held at zero while reset is asserted
    always_comb begin
        imem_read     = 1'b0;
        dmem_req      = 1'b0;
        dmem_phase    = 1'b0;
        load_pc       = 1'b0;
        load_ifid     = 1'b0;
        load_idex     = 1'b0;
        load_exmem    = 1'b0;
        load_memwb    = 1'b0;
        bubble_ifid   = 1'b0;
        bubble_idex   = 1'b0;
        bubble_exmem  = 1'b0;
        pc_sel_branch = 1'b0;
        stall_count   = '0;
        if (reset) begin
            imem_read     = !fetched_q;
            dmem_req      = (mstate_q != M_IDLE) || mem_access;
            dmem_phase    = (mstate_q == M_ACC2);
            load_pc       = load_pc_s;
            load_ifid     = load_ifid_s;
            load_idex     = load_idex_s;
            load_exmem    = load_exmem_s;
            load_memwb    = load_memwb_s;
            bubble_ifid   = bubble_ifid_s;
            bubble_idex   = bubble_idex_s;
            bubble_exmem  = bubble_exmem_s;
            pc_sel_branch = pc_sel_branch_s;
            stall_count   = stall_count_q;
        end else begin
            stall_count = '0;
        end
    end

endmodule
